// File: rtl/axis_unsharp_filter.sv
// AXI4-Stream RGB unsharp-mask filter: RGB->YUV, luma minus causal box blur, YUV->RGB clamp.
// Defining UNSHARP_CLIP_CNT_EN adds the clipped-pixel counter; otherwise clip_count is 0.
module axis_unsharp_filter #(
  parameter int CH_W  = 8,
  parameter int WIN   = 8,
  parameter int AMT_W = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_enable,
  input  logic [AMT_W-1:0]  cfg_amount,
  input  logic [3*CH_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [3*CH_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [31:0]       clip_count
);
  localparam int PW = 3*CH_W;
  localparam int AW = CH_W + AMT_W + 12;
  localparam int LW = $clog2(WIN);
  typedef logic signed [AW-1:0] sw_t;
  localparam sw_t MAXV = sw_t'((1 << CH_W) - 1);
  localparam sw_t K77  = sw_t'(77);
  localparam sw_t K150 = sw_t'(150);
  localparam sw_t K29  = sw_t'(29);
  localparam sw_t K128 = sw_t'(128);
  localparam sw_t K43  = sw_t'(43);
  localparam sw_t K85  = sw_t'(85);
  localparam sw_t K107 = sw_t'(107);
  localparam sw_t K21  = sw_t'(21);
  localparam sw_t K143 = sw_t'(143);
  localparam sw_t K44  = sw_t'(44);
  localparam sw_t K91  = sw_t'(91);
  localparam sw_t K179 = sw_t'(179);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1.
  // The whole pipeline moves as one (ce); s_axis_tready is ce, so a full output
  // register that is not being taken freezes every stage and the input port.
  logic ce;
  assign ce = m_axis_tready | ~m_axis_tvalid;
  assign s_axis_tready = ce;

  logic v0, v1, v2, v3, v4;
  logic last0, last1, last2, last3, last4;
  logic user0, user1, user2, user3, user4;
  logic en0, en1, en2, en3;
  logic [AMT_W-1:0] amt0, amt1, amt2;
  logic [PW-1:0] d0, d1, d2, d3, px4;
  sw_t y1, cu1, cv1, y2, cu2, cv2, det2, ys3, cu3, cv3;
  sw_t taps [0:WIN-2];
  logic line_start;

  sw_t r_in, g_in, b_in, y_c, cu_c, cv_c, acc, det_c, ys_c, r_c, g_c, b_c;
  logic ls_c;
  logic [PW-1:0] px_c;

  function automatic logic [CH_W-1:0] clamp(input sw_t x);
    if (x[AW-1]) return '0;
    else if (x > MAXV) return '1;
    else return x[CH_W-1:0];
  endfunction

`ifdef UNSHARP_CLIP_CNT_EN
  logic clip_c, clip4, out_clip;
  logic [31:0] clip_cnt;

  function automatic logic is_clip(input sw_t x);
    return x[AW-1] | (x > MAXV);
  endfunction
`endif

  always_comb begin
    r_in  = sw_t'(d0[PW-1 -: CH_W]);
    g_in  = sw_t'(d0[2*CH_W-1 -: CH_W]);
    b_in  = sw_t'(d0[CH_W-1:0]);
    y_c   = (K77 * r_in + K150 * g_in + K29 * b_in) >>> 8;
    cu_c  = (K128 * b_in - K43 * r_in - K85 * g_in) >>> 8;
    cv_c  = (K128 * r_in - K107 * g_in - K21 * b_in) >>> 8;
    // A line start sees a window full of its own luma, so its detail is zero.
    ls_c  = line_start | user1;
    acc   = y1;
    for (int i = 0; i < WIN-1; i++) acc = acc + taps[i];
    det_c = ls_c ? '0 : (y1 - (acc >>> LW));
    ys_c  = y2 + ((sw_t'(amt2) * det2) >>> 2);
    r_c   = ys3 + ((K143 * cv3) >>> 7);
    g_c   = ys3 - ((K44 * cu3 + K91 * cv3) >>> 7);
    b_c   = ys3 + ((K179 * cu3) >>> 7);
    px_c  = en3 ? {clamp(r_c), clamp(g_c), clamp(b_c)} : d3;
`ifdef UNSHARP_CLIP_CNT_EN
    clip_c = en3 & (is_clip(r_c) | is_clip(g_c) | is_clip(b_c));
`endif
  end

  // Control path: valids, sideband, window history and output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      {v0, v1, v2, v3, v4} <= '0;
      {last0, last1, last2, last3, last4} <= '0;
      {user0, user1, user2, user3, user4} <= '0;
      for (int i = 0; i < WIN-1; i++) taps[i] <= '0;
      line_start    <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
`ifdef UNSHARP_CLIP_CNT_EN
      out_clip      <= 1'b0;
`endif
    end else if (ce) begin
      v0 <= s_axis_tvalid; last0 <= s_axis_tlast; user0 <= s_axis_tuser;
      v1 <= v0; last1 <= last0; user1 <= user0;
      v2 <= v1; last2 <= last1; user2 <= user1;
      v3 <= v2; last3 <= last2; user3 <= user2;
      v4 <= v3; last4 <= last3; user4 <= user3;
      if (v1) begin
        line_start <= last1;
        taps[0]    <= y1;
        for (int i = 1; i < WIN-1; i++) taps[i] <= ls_c ? y1 : taps[i-1];
      end
      m_axis_tvalid <= v4;
      m_axis_tdata  <= px4;
      m_axis_tlast  <= last4;
      m_axis_tuser  <= user4;
`ifdef UNSHARP_CLIP_CNT_EN
      out_clip      <= clip4;
`endif
    end
  end

  // Data path registers need no reset: they are only observed behind a valid.
  always_ff @(posedge aclk) begin
    if (ce) begin
      d0 <= s_axis_tdata; en0 <= cfg_enable; amt0 <= cfg_amount;
      d1 <= d0; en1 <= en0; amt1 <= amt0;
      y1 <= y_c; cu1 <= cu_c; cv1 <= cv_c;
      d2 <= d1; en2 <= en1; amt2 <= amt1;
      y2 <= y1; cu2 <= cu1; cv2 <= cv1; det2 <= det_c;
      d3 <= d2; en3 <= en2;
      ys3 <= ys_c; cu3 <= cu2; cv3 <= cv2;
      px4 <= px_c;
`ifdef UNSHARP_CLIP_CNT_EN
      clip4 <= clip_c;
`endif
    end
  end

`ifdef UNSHARP_CLIP_CNT_EN
  // A start-of-frame beat restarts the count, including its own clip.
  always_ff @(posedge aclk) begin
    if (areset) begin
      clip_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tuser) clip_cnt <= {31'b0, out_clip};
      else if (out_clip && (clip_cnt != '1)) clip_cnt <= clip_cnt + 32'd1;
    end
  end
  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif
endmodule

// File: tb/tb_axis_unsharp_filter.sv
// Randomized scoreboard bench for axis_unsharp_filter against a behavioural reference model.
module tb_axis_unsharp_filter;
  localparam int CH_W = 8;
  localparam int WIN = 8;
  localparam int AMT_W = 4;
  localparam int PW = 3*CH_W;
  localparam int W = PW + 3;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              cfg_enable = 1'b1;
  logic [AMT_W-1:0]  cfg_amount = '0;
  logic [PW-1:0]     s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tuser = 1'b0;
  logic [PW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [31:0]       clip_count;

  axis_unsharp_filter #(.CH_W(CH_W), .WIN(WIN), .AMT_W(AMT_W)) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_amount(cfg_amount),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .clip_count(clip_count)
  );

  // clock / reset-independent housekeeping
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_last = 0;
  int hs_edge = 0;
  logic bp_mode = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [31:0] exp_clip = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: per-line luma history with first-pixel replication
  int hist[$];
  bit mdl_ls = 1'b1;

  function automatic int clamp_i(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic logic [W-1:0] model(input logic [PW-1:0] px, input logic last,
                                         input logic user, input logic en, input int amt);
    int r, g, b, y, u, v, sum, d, ys, ro, go, bo, n;
    logic clip;
    logic [PW-1:0] o;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    y = (77*r + 150*g + 29*b) >>> 8;
    u = (128*b - 43*r - 85*g) >>> 8;
    v = (128*r - 107*g - 21*b) >>> 8;
    if (mdl_ls || user) hist.delete();
    mdl_ls = last;
    hist.push_back(y);
    if (hist.size() > WIN) void'(hist.pop_front());
    n = hist.size();
    sum = 0;
    for (int k = 0; k < WIN; k++) sum += (k < n) ? hist[n-1-k] : hist[0];
    d  = y - sum / WIN;
    ys = y + ((amt * d) >>> 2);
    ro = ys + ((143*v) >>> 7);
    go = ys - ((44*u + 91*v) >>> 7);
    bo = ys + ((179*u) >>> 7);
    clip = en && (ro < 0 || ro > 255 || go < 0 || go > 255 || bo < 0 || bo > 255);
    o = en ? {8'(clamp_i(ro)), 8'(clamp_i(go)), 8'(clamp_i(bo))} : px;
    return {clip, user, last, o};
  endfunction

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send_beat(input logic [PW-1:0] px, input logic last, input logic user,
                           input logic en, input int amt, input int ovr);
    int waitc;
    logic [W-1:0] e;
    bit ok;
    s_axis_tdata = px; s_axis_tlast = last; s_axis_tuser = user;
    cfg_enable = en; cfg_amount = AMT_W'(amt);
    s_axis_tvalid = 1'b1;
    waitc = 0;
    ok = 1'b0;
    while (!ok && waitc < 1000) begin
      @(negedge aclk);
      if (s_axis_tready) ok = 1'b1;
      else waitc++;
    end
    if (!ok) begin
      chk("send_timeout", 64'(0), 64'(1));
    end else begin
      hs_edge = cyc + 1;
      e = model(px, last, user, en, amt);
      if (ovr >= 0) e[PW-1:0] = ovr[PW-1:0];
      exp_q.push_back(e);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
  endtask

  task automatic lat_check(input string name);
    int t;
    t = 0;
    @(negedge aclk);
    while (!m_axis_tvalid && t < 20) begin
      @(negedge aclk);
      t++;
    end
    chk(name, 64'(cyc - hs_edge), 64'(5));
    sync();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge aclk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // output backpressure generator
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // monitor / scoreboard
  logic held_v = 1'b0;
  logic [PW+1:0] held;
  always @(negedge aclk) begin : monitor
    logic [W-1:0] e;
    if (areset) begin
      exp_q.delete();
      exp_clip = '0;
      held_v = 1'b0;
    end else begin
      chk("clip_count", 64'(clip_count), 64'(exp_clip));
      if (held_v) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
        chk("hold_data", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'(held));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (m_axis_tlast) n_last++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tdata), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(m_axis_tdata), 64'(e[PW-1:0]));
          chk("out_last", 64'(m_axis_tlast), 64'(e[PW]));
          chk("out_user", 64'(m_axis_tuser), 64'(e[PW+1]));
`ifdef UNSHARP_CLIP_CNT_EN
          if (e[PW+1]) exp_clip = {31'b0, e[PW+2]};
          else if (e[PW+2] && exp_clip != 32'hffff_ffff) exp_clip = exp_clip + 32'd1;
`endif
        end
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached with %0d beats pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int ovr, n0, l0, exp8;
    logic [PW-1:0] px;
    areset = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_tuser", 64'(m_axis_tuser), 64'(0));
    chk("rst_clip", 64'(clip_count), 64'(0));
    chk("rst_tready", 64'(s_axis_tready), 64'(1));
    sync();

    // flat gray 128 with max amount, first-beat latency
    for (int i = 0; i < 32; i++) begin
      send_beat({3{8'd128}}, (i % 16) == 15, i == 0, 1'b1, 15, 24'h808080);
      if (i == 0) lat_check("latency_flat");
    end
    drain();

    // step edge, amount 1
    for (int i = 0; i < 16; i++) begin
      px = (i < 8) ? {3{8'd64}} : {3{8'd192}};
      ovr = -1;
      if (i < 8) ovr = 24'h404040;
      else if (i == 8) ovr = 24'hdcdcdc;
      send_beat(px, i == 15, i == 0, 1'b1, 1, ovr);
    end
    drain();

    // step edge, amount 4, two lines
    for (int i = 0; i < 32; i++) begin
      px = ((i % 16) < 8) ? {3{8'd64}} : {3{8'd192}};
      ovr = -1;
      if ((i % 16) < 8) ovr = 24'h404040;
      else if ((i % 16) < 12) ovr = 24'hffffff;
      else if ((i % 16) == 12) ovr = 24'hf0f0f0;
      send_beat(px, (i % 16) == 15, i == 0, 1'b1, 4, ovr);
    end
    drain();
`ifdef UNSHARP_CLIP_CNT_EN
    exp8 = 8;
`else
    exp8 = 0;
`endif
    chk("clip_two_lines", 64'(clip_count), 64'(exp8));

    // line-edge replication: line ends at 64, next starts at 192
    for (int i = 0; i < 16; i++) begin
      px = ((i < 4) || (i >= 8)) ? {3{8'd192}} : {3{8'd64}};
      send_beat(px, i == 7 || i == 15, i == 0, 1'b1, 15, (i == 8) ? 24'hc0c0c0 : -1);
    end
    drain();

    // backpressure over a 64x4 frame
    bp_mode = 1'b1;
    n0 = n_out;
    l0 = n_last;
    for (int i = 0; i < 256; i++) begin
      px = PW'($urandom);
      send_beat(px, (i % 64) == 63, i == 0, 1'b1, 6, -1);
    end
    drain();
    chk("bp_beats", 64'(n_out - n0), 64'(256));
    chk("bp_lasts", 64'(n_last - l0), 64'(4));

    // randomized mix: gaps, sideband, cfg changes, backpressure
    for (int i = 0; i < 300; i++) begin
      px = PW'($urandom);
      send_beat(px, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), -1);
      repeat ($urandom_range(0, 2)) sync();
    end
    drain();
    bp_mode = 1'b0;
    sync();

    // reset mid-line
    for (int i = 0; i < 5; i++) send_beat(PW'($urandom), 1'b0, i == 0, 1'b1, 15, -1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    mdl_ls = 1'b1;
    hist.delete();
    @(negedge aclk);
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("midrst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("midrst_clip", 64'(clip_count), 64'(0));
    chk("midrst_tready", 64'(s_axis_tready), 64'(1));
    sync();
    drain();

    // bypass: output equals input at the same latency
    px = 24'h3a7fc1;
    send_beat(px, 1'b0, 1'b1, 1'b0, 9, int'(px));
    lat_check("latency_bypass");
    for (int i = 0; i < 20; i++) begin
      px = PW'($urandom);
      send_beat(px, i == 19, 1'b0, 1'b0, int'($urandom_range(0, 15)), int'(px));
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_unsharp_filter.md
# axis_unsharp_filter

Parametrised AXI4-Stream RGB unsharp-mask filter. It converts each pixel to YUV and subtracts a causal horizontal box blur of width WIN from luma, scaled by a per-beat programmable amount. It converts back to clamped RGB. It sits in the video path between the frame source and the display/VDMA sink. Unlike the previous generation it provides full backpressure, sideband alignment, line-edge replication and a run-time bypass.

## Interface

**Parameters**
- CH_W, 8: bits per colour channel; tdata is 3*CH_W wide, packed {R,G,B}.
- WIN, 8: blur window taps. Power of two, 2..16.
- AMT_W, 4: width of cfg_amount. Gain = cfg_amount/4.

**Ports**
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  1 = filter, 0 = bypass. Sampled per accepted beat.
- cfg_amount  in  AMT_W  sharpening amount. Sampled per accepted beat.
- s_axis_tdata  in  3*CH_W  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- m_axis_tdata  out  3*CH_W  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of line, aligned with its pixel.
- m_axis_tuser  out  1  start of frame, aligned with its pixel.
- clip_count  out  32  clipped-pixel counter (see Configuration).

## Operation

**Pipeline**
- Five stages, each carrying its own valid bit:
  - S0 input register;
  - S1 RGB→YUV;
  - S2 window sum and detail;
  - S3 sharpen;
  - S4 YUV→RGB with clamp, which also drives the output register.
- tdata_in, tlast, tuser, cfg_enable and cfg_amount travel with the pixel through every stage.

**Arithmetic**
- All arithmetic is signed with at least CH_W+8 bits. `>>>` is arithmetic shift.
- Y = (77R+150G+29B)>>8
- U = (128B−43R−85G)>>>8
- V = (128R−107G−21B)>>>8
- Yblur = (sum of the last WIN Y values, current included) >>> log2(WIN)
- D = Y − Yblur
- Ys = Y + ((cfg_amount·D)>>>2)
- R = Ys + ((143V)>>>7)
- G = Ys − ((44U+91V)>>>7)
- B = Ys + ((179U)>>>7)
- Each channel is clamped to [0, 2^CH_W−1].

**Line-edge replication**
- A beat is a line start if it is the first beat after reset, the first beat after a tlast beat, or any beat with tuser=1.
- On a line start, every window tap is loaded with that pixel's Y. The first pixel of every line therefore has D=0.

**Bypass**
- With cfg_enable=0 the output pixel is that beat's original tdata.
- Latency and sideband behaviour are unchanged in bypass.
- Window history still updates in bypass.

## Timing

**Stall control**
- ce = m_axis_tready | ~m_axis_tvalid.
- s_axis_tready = ce. This is a combinational path from m_axis_tready.
- Every stage advances only when ce=1. Bubbles are not collapsed.

**Latency and throughput**
- A beat accepted at edge k is presented on m_axis at edge k+5, with m_axis_tready held high.
- Throughput is 1 pixel per clock.

**Output holding**
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs hold stable.
- No beat is dropped or duplicated.

**Reset**
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, clip_count=0.
- Reset also clears all stage valids and window taps, and sets the line-start flag.
- Reset asserted mid-frame discards in-flight beats. Outputs take their reset values at the next edge.
- s_axis_tready is 1 one cycle after reset deasserts.

**Corner cases**
- tlast and tuser on the same beat: the beat is a line start and the next beat is also a line start.
- cfg_* changes mid-line take effect on the first beat accepted after the change.

## Configuration

The feature is controlled by the macro UNSHARP_CLIP_CNT_EN.

**Defined**
- clip_count increments by 1 for each output beat with cfg_enable=1 where any channel saturated during clamping.
- The increment happens on the output handshake.
- clip_count resets to 0 on a handshake of a beat with tuser=1; that beat's own clip is counted from 1.
- clip_count saturates at 2^32−1.

**Undefined**
- clip_count is tied to 0 and no counter logic is synthesised.

## Test plan

WIN=8, CH_W=8 unless noted.

1. **Flat gray:** flat gray 128 frame, cfg_amount=15, m_axis_tready=1 → every output = {128,128,128}; first m_axis_tvalid 5 cycles after first handshake.
2. **Step edge, amount 1:** 16-px line of 8×gray 64 then 8×gray 192, cfg_amount=1 → first 192-side output {220,220,220}. 64-side outputs stay {64,64,64}.
3. **Step edge, amount 4:** same line with cfg_amount=4 → the first four 192-side outputs are {255,255,255}, the fifth is {240,240,240}. Two such lines with UNSHARP_CLIP_CNT_EN give clip_count=8.
4. **Line-edge replication:** line ending gray 64 (tlast), next line starts gray 192 → first output of new line {192,192,192}, with no overshoot from the previous line. tlast/tuser appear on m_axis with their own pixels.
5. **Backpressure:** random m_axis_tready (50%) over a 64×4 frame → the output sequence is identical to the unstalled run. m_axis_tdata holds while stalled. Exactly 256 beats, with tlast on beats 64, 128, 192 and 256.
6. **Reset and bypass:** one-cycle areset mid-line → next cycle m_axis_tvalid=0, m_axis_tdata=0, clip_count=0. With cfg_enable=0 → output equals input tdata at 5-cycle latency.
